// File: rtl/reg_bank_pkg.sv
// Shared register-file constants and RegDest select encodings for the multicycle MIPS datapath.
package reg_bank_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

  localparam logic [WORD_W-1:0] SP_RESET_VAL = 32'd227;

  typedef enum logic [1:0] {
    RD_RT = 2'd0,
    RD_RA = 2'd1,
    RD_SP = 2'd2,
    RD_RD = 2'd3
  } reg_dest_e;

endpackage

// File: rtl/reg_bank_read_port.sv
// One combinational read port: index decode, $zero forcing and, with REG_BANK_BYPASS_EN,
// same-cycle forwarding of the in-flight write-back word.
module reg_bank_read_port
  import reg_bank_pkg::*;
#(
  parameter int DATA_W = WORD_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs,
`ifdef REG_BANK_BYPASS_EN
  input  logic                               reset,
  input  logic                               reg_write,
  input  logic [ADDR_W-1:0]                  write_reg,
  input  logic [DATA_W-1:0]                  write_data,
`endif
  input  logic [ADDR_W-1:0]                  read_reg,
  output logic [DATA_W-1:0]                  read_data
);

  logic fwd_hit_s;

`ifdef REG_BANK_BYPASS_EN
  assign fwd_hit_s = reg_write && !reset && (write_reg == read_reg);
`else
  assign fwd_hit_s = 1'b0;
`endif

  // Port mux: $zero always reads 0, forwarding beats storage.
  always_comb begin
    read_data = '0;
    if (read_reg == ADDR_W'(REG_ZERO)) begin
      read_data = '0;
    end else if (fwd_hit_s) begin
`ifdef REG_BANK_BYPASS_EN
      read_data = write_data;
`else
      read_data = '0;
`endif
    end else begin
      read_data = regs[read_reg];
    end
  end

endmodule

// File: rtl/reg_bank.sv
// 32 x 32-bit MIPS register file: clocked writes, two combinational read ports.
// Optional write-through forwarding is enabled by defining REG_BANK_BYPASS_EN.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int                DATA_W   = WORD_W,
  parameter int                ADDR_W   = REG_ADDR_W,
  parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(SP_RESET_VAL)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  localparam int NUM_REGS = 2**ADDR_W;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_r;

  // Storage: reset overrides any write in the same cycle; $zero is never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
      regs_r[ADDR_W'(REG_SP)] <= SP_RESET;
    end else if (reg_write && (write_reg != ADDR_W'(REG_ZERO))) begin
      regs_r[write_reg] <= write_data;
    end else begin
      regs_r <= regs_r;
    end
  end

  reg_bank_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port1 (
    .regs       (regs_r),
`ifdef REG_BANK_BYPASS_EN
    .reset      (reset),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
`endif
    .read_reg   (read_reg1),
    .read_data  (read_data1)
  );

  reg_bank_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port2 (
    .regs       (regs_r),
`ifdef REG_BANK_BYPASS_EN
    .reset      (reset),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
`endif
    .read_reg   (read_reg2),
    .read_data  (read_data2)
  );

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios plus a randomized sweep against
// an array-based reference model (honours REG_BANK_BYPASS_EN when defined).
module tb_reg_bank;

  logic        clk;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  int vectors;
  int miscompares;

  logic [31:0] model [32];

  reg_bank dut (
    .clk        (clk),
    .reset      (reset),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural effect of one rising edge given the current inputs.
  function automatic void model_edge();
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      model[29] = 32'd227;
    end else if (reg_write && write_reg != 5'd0) begin
      model[write_reg] = write_data;
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
`ifdef REG_BANK_BYPASS_EN
    if (reg_write && !reset && write_reg == idx) return write_data;
`endif
    return model[idx];
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    reset = 1'b1; reg_write = 1'b0; write_reg = 5'd0; write_data = 32'd0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i); read_reg2 = 5'(i);
      exp = (i == 29) ? 32'd227 : 32'd0;
      #1;
      vectors++;
      if (read_data1 !== exp) begin
        miscompares++;
        $display("FAIL reset_rd1 reg=%0d got=%h exp=%h", i, read_data1, exp);
      end
      vectors++;
      if (read_data2 !== exp) begin
        miscompares++;
        $display("FAIL reset_rd2 reg=%0d got=%h exp=%h", i, read_data2, exp);
      end
    end
  endtask

  task automatic test_write_read();
    reg_write = 1'b1; write_reg = 5'd8; write_data = 32'hDEADBEEF;
    tick();
    reg_write = 1'b0;
    read_reg1 = 5'd8; read_reg2 = 5'd8;
    #1;
    vectors++;
    if (read_data1 !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL write_rd1 got=%h exp=%h", read_data1, 32'hDEADBEEF);
    end
    vectors++;
    if (read_data2 !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL write_rd2 got=%h exp=%h", read_data2, 32'hDEADBEEF);
    end
    read_reg1 = 5'd7; read_reg2 = 5'd9;
    #1;
    vectors++;
    if (read_data1 !== 32'd0 || read_data2 !== 32'd0) begin
      miscompares++;
      $display("FAIL write_neighbours got=%h/%h exp=0/0", read_data1, read_data2);
    end
  endtask

  task automatic test_zero_reg();
    reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hFFFFFFFF;
    read_reg1 = 5'd0; read_reg2 = 5'd0;
    #1;
    vectors++;
    if (read_data1 !== 32'd0 || read_data2 !== 32'd0) begin
      miscompares++;
      $display("FAIL zero_same_cycle got=%h/%h exp=0/0", read_data1, read_data2);
    end
    tick();
    reg_write = 1'b0;
    #1;
    vectors++;
    if (read_data1 !== 32'd0) begin
      miscompares++;
      $display("FAIL zero_after got=%h exp=0", read_data1);
    end
  endtask

  task automatic test_reset_priority();
    reg_write = 1'b1; write_reg = 5'd31; write_data = 32'h55;
    tick();
    reset = 1'b1; write_data = 32'h1234;
    tick();
    reset = 1'b0; reg_write = 1'b0;
    read_reg1 = 5'd31; read_reg2 = 5'd29;
    #1;
    vectors++;
    if (read_data1 !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_wins_r31 got=%h exp=0", read_data1);
    end
    vectors++;
    if (read_data2 !== 32'd227) begin
      miscompares++;
      $display("FAIL reset_wins_r29 got=%h exp=%h", read_data2, 32'd227);
    end
  endtask

  task automatic test_sp_same_cycle();
    logic [31:0] exp_now;
`ifdef REG_BANK_BYPASS_EN
    exp_now = 32'h100;
`else
    exp_now = 32'd227;
`endif
    reg_write = 1'b1; write_reg = 5'd29; write_data = 32'h100; read_reg2 = 5'd29;
    #1;
    vectors++;
    if (read_data2 !== exp_now) begin
      miscompares++;
      $display("FAIL sp_before_edge got=%h exp=%h", read_data2, exp_now);
    end
    tick();
    reg_write = 1'b0;
    #1;
    vectors++;
    if (read_data2 !== 32'h100) begin
      miscompares++;
      $display("FAIL sp_after_edge got=%h exp=%h", read_data2, 32'h100);
    end
  endtask

  task automatic test_back_to_back();
    reg_write = 1'b1; write_reg = 5'd31; write_data = 32'h4; read_reg1 = 5'd31;
    tick();
    #1;
    vectors++;
    if (read_data1 !== 32'h4) begin
      miscompares++;
      $display("FAIL b2b_first got=%h exp=%h", read_data1, 32'h4);
    end
    write_data = 32'h8;
    tick();
    reg_write = 1'b0;
    #1;
    vectors++;
    if (read_data1 !== 32'h8) begin
      miscompares++;
      $display("FAIL b2b_second got=%h exp=%h", read_data1, 32'h8);
    end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int c = 0; c < 10000; c++) begin
      reset      = ($urandom_range(0, 63) == 0);
      reg_write  = $urandom_range(0, 1) == 1;
      write_reg  = 5'($urandom_range(0, 31));
      write_data = $urandom;
      read_reg1  = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
      read_reg2  = 5'($urandom_range(0, 31));
      #1;
      e1 = model_read(read_reg1);
      e2 = model_read(read_reg2);
      vectors++;
      if (read_data1 !== e1) begin
        miscompares++;
        $display("FAIL rand_rd1 cyc=%0d reg=%0d got=%h exp=%h", c, read_reg1, read_data1, e1);
      end
      vectors++;
      if (read_data2 !== e2) begin
        miscompares++;
        $display("FAIL rand_rd2 cyc=%0d reg=%0d got=%h exp=%h", c, read_reg2, read_data2, e2);
      end
      tick();
    end
    reset = 1'b0; reg_write = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b0; reg_write = 1'b0; write_reg = 5'd0; write_data = 32'd0;
    read_reg1 = 5'd0; read_reg2 = 5'd0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_zero_reg();
    test_reset_priority();
    test_sp_same_cycle();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
